i2c_target: RTL
===============

// Module: i2c_target
// PURPOSE
//  I2C target (slave) responder, 7-bit addressing, clk-oversampled (no logic clocked by scl).
//  Answers master reads by shifting bytes from a tx byte stream onto sda.
//  Delivers master-written bytes on an rx strobe interface.
//  Sits at the bus pins opposite an I2C master; the user side feeds and consumes bytes.
// PARAMETERS
//  TARGET_ADDR  7'h48  7-bit address this target acknowledges
//  SYNC_STAGES  2      flip-flop stages on scl/sda inputs (>=2)
//  IDLE_BYTE    8'hFF  byte sent on a read when tx_valid=0 at load time
// PORTS
//  clk       in     1  system clock
//  reset     in     1  synchronous, active-high
//  scl       in     1  bus clock from master
//  sda       inout  1  open-drain data; driven 0 or z only, never 1
//  tx_data   in     8  next byte to send on a read
//  tx_valid  in     1  tx_data is valid
//  tx_ready  out    1  1-clk pulse: tx_data consumed
//  rx_data   out    8  last byte written by master; held until next byte
//  rx_valid  out    1  1-clk pulse: rx_data updated
//  addr_hit  out    1  1-clk pulse: address matched, ACK being driven
//  rw        out    1  R/W bit of current transfer (1=read); valid from addr_hit until STOP
//  busy      out    1  1 from address match until STOP or restart
// BEHAVIOUR
//  Reset: sda released (z), state IDLE, rx_data=0, rw=0, all pulse outputs and busy 0.
//  Inputs pass SYNC_STAGES FFs, then edge detect. Pin-to-reaction latency SYNC_STAGES+1 clk.
//  Bus requirement: scl high and low phases each >= SYNC_STAGES+3 clk.
//  START = sda fall while scl high; STOP = sda rise while scl high.
//    Both are detected in every state, including mid-byte.
//  Bit counter: 3 bits; data sampled on scl rise; sda drive changes only on scl fall.
//  States and transitions:
//   IDLE: wait for START -> ADDR.
//   ADDR: shift 8 bits, MSB first (7 address bits + R/W).
//     After 8th rise, address == TARGET_ADDR -> ADDR_ACK, else -> IDLE (no drive until next START).
//   ADDR_ACK: on next scl fall drive sda=0, pulse addr_hit, latch rw, busy=1.
//     Next scl fall: rw=0 -> release sda, go WR_DATA.
//     rw=1 -> load byte, drive MSB, go RD_DATA.
//   WR_DATA: shift 8 bits. On 8th rise: rx_data<=byte, pulse rx_valid, go WR_ACK.
//   WR_ACK: drive 0 from next fall to the following fall, then release -> WR_DATA.
//     Every write byte is ACKed; no backpressure.
//   RD_DATA: drive sda=0 for 0 bits, z for 1 bits; change on each fall.
//     After the 8th bit's fall, release sda -> RD_ACK.
//   RD_ACK: sample sda on rise.
//     0 (ACK): on next fall load next byte, drive MSB -> RD_DATA.
//     1 (NACK): -> RD_WAIT, sda released.
//   RD_WAIT: ignore bits; wait for STOP/START.
//  Byte load: if tx_valid, take tx_data and pulse tx_ready in the same clk.
//    Else send IDLE_BYTE, no tx_ready.
//  STOP in any state: release sda within 1 clk, busy=0 -> IDLE.
//  START in any non-IDLE state (repeated start): release sda, clear bit counter -> ADDR.
//    busy drops and is reasserted only on a new match.
//  Simultaneous scl and sda edges in one clk: treat as data, not START/STOP.
//  Reset mid-transfer: sda released the next clk, pending pulses dropped.
//  Only one pulse output fires per clk; pulses never repeat for the same byte.
// STRUCTURE
//  Shared package i2c_pkg holds:
//   state encoding (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, RD_WAIT);
//   I2C_ACK=1'b0, I2C_NACK=1'b1; I2C_READ=1'b1.
//  Sub-module i2c_sync_edge: N-stage synchronizer plus rise/fall strobes.
//    Instanced for scl and for sda.
//  FSM, shift register and bit counter stay in i2c_target.
// TESTING
//  1. Master reads 2 bytes from 0x48, tx stream {A5,3C}, ACK then NACK, then STOP
//     -> ACK on 9th bit; bus shows A5, 3C; 2 tx_ready pulses; busy 0 after STOP.
//  2. Master writes 0x90 then 0x12, 0x34 -> ACK on all 3 bytes.
//     rx_valid pulses twice with rx_data 12 then 34; rw=0.
//  3. Address 0x49 read -> sda never driven; no addr_hit.
//     Following 0x48 read answers normally.
//  4. Read with tx_valid=0 -> bus byte FF, no tx_ready.
//  5. Write 0x90, 0x55, repeated START, read 0x91 -> rx 55.
//     Second addr_hit with rw=1, read data sourced from tx stream.
//  6. reset asserted after 4th bit of RD_DATA while driving 0 -> sda z the next clk.
//     Outputs at reset values; the next START/0x48 works.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and bus-level constants.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    RD_WAIT
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic I2C_READ = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-stage synchronizer for an asynchronous bus pin, with one-clk rise/fall strobes
// derived from the synchronized level.
module i2c_sync_edge
  import i2c_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  // Reset to the idle bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target with 7-bit addressing, oversampled on clk; streams tx bytes out on reads
// and strobes received bytes on writes.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h48,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_hit,
  output logic       rw,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_scl_sync (
    .clk   (clk),
    .reset (reset),
    .din   (scl),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sda_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sda),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       sda_low_q, sda_low_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       addr_hit_q, addr_hit_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       mack_q, mack_d;

  logic       scl_quiet, start_det, stop_det;
  logic [7:0] rx_byte, load_byte;
  logic       load;

  // An sda edge coinciding with an scl edge is treated as data, never as START/STOP.
  assign scl_quiet = ~scl_rise & ~scl_fall;
  assign start_det = sda_fall & scl_lvl & scl_quiet;
  assign stop_det  = sda_rise & scl_lvl & scl_quiet;
  assign rx_byte   = {shift_q[6:0], sda_lvl};
  assign load_byte = tx_valid ? tx_data : IDLE_BYTE;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    sda_low_d  = sda_low_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    addr_hit_d = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;
    mack_d     = mack_q;
    load       = 1'b0;

    if (stop_det) begin
      state_d   = IDLE;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 3'd0;
      mack_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 3'd0;
      mack_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
        end

        ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = (shift_q[6:0] == TARGET_ADDR) ? ADDR_ACK : IDLE;
            end
          end
        end

        // sda_low_q distinguishes the fall that starts the ACK bit from the one ending it.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d  = 1'b1;
              addr_hit_d = 1'b1;
              rw_d       = shift_q[0];
              busy_d     = 1'b1;
            end else if (rw_q == I2C_READ) begin
              load    = 1'b1;
              state_d = RD_DATA;
            end else begin
              sda_low_d = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = WR_DATA;
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = rx_byte;
              rx_valid_d = 1'b1;
              state_d    = WR_ACK;
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = WR_DATA;
            end
          end
        end

        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_low_d = 1'b0;
              bit_cnt_d = 3'd0;
              mack_d    = 1'b0;
              state_d   = RD_ACK;
            end else begin
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
              sda_low_d  = ~tx_shift_q[6];
              bit_cnt_d  = bit_cnt_q + 3'd1;
            end
          end
        end

        // mack_q remembers a master ACK seen on the rise until the closing fall.
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == I2C_ACK) begin
              mack_d = 1'b1;
            end else begin
              state_d = RD_WAIT;
            end
          end else if (scl_fall && mack_q) begin
            mack_d  = 1'b0;
            load    = 1'b1;
            state_d = RD_DATA;
          end
        end

        RD_WAIT: begin
        end

        default: state_d = IDLE;
      endcase
    end

    if (load) begin
      tx_shift_d = load_byte;
      sda_low_d  = ~load_byte[7];
      bit_cnt_d  = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      tx_shift_q <= 8'h00;
      sda_low_q  <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      addr_hit_q <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      mack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      sda_low_q  <= sda_low_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      addr_hit_q <= addr_hit_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      mack_q     <= mack_d;
    end
  end

  assign sda      = sda_low_q ? 1'b0 : 1'bz;
  assign tx_ready = load & tx_valid & ~reset;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign addr_hit = addr_hit_q;
  assign rw       = rw_q;
  assign busy     = busy_q;

endmodule
